glogic_pipe: RTL and testbench

Parametrised, registered bitwise logic unit: the pipelined successor to the combinational 16-bit gate blocks (AND/OR/NOT family). One cycle computes any of eight bitwise operations on two WIDTH-bit operands, or folds an operand into an internal accumulator. Results land in a 2-entry output buffer behind valid/ready handshakes on both sides. It sits between an operand producer and any consumer that may stall.

---
 rtl/glogic_pipe.sv | 132 +++++++++++++
 tb/tb_glogic_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glogic_pipe.sv
// glogic_pipe: registered bitwise logic unit with accumulator
// and a 2-entry in-order valid/ready result buffer.
module glogic_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero
);

   localparam logic [1:0] MODE_ACC  = 2'b01;
   localparam logic [1:0] MODE_LOAD = 2'b10;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HALF  = 2'b01,
      FULL  = 2'b10
   } occ_t;

   occ_t             state;
   occ_t             state_nx;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] z;
   logic [WIDTH-1:0] r;
   logic             r_zero;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic             z0;
   logic             z1;
   logic             push;
   logic             pop;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign y         = d0;
   assign zero      = z0;

   always_comb begin
      x = a;
      z = b;
      if (mode == MODE_ACC) begin
         x = acc;
         z = a;
      end
   end

   always_comb begin
      r = z;
      unique case (op)
         3'b000: r = x & z;
         3'b001: r = x | z;
         3'b010: r = x ^ z;
         3'b011: r = ~(x & z);
         3'b100: r = ~(x | z);
         3'b101: r = ~(x ^ z);
         3'b110: r = ~x;
         3'b111: r = z;
      endcase
      if (mode == MODE_LOAD) r = a;
   end

   assign r_zero = (r == '0);

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (push) state_nx = HALF;
         HALF: begin
            if (push && !pop) state_nx = FULL;
            else if (pop && !push) state_nx = EMPTY;
         end
         FULL: if (pop) state_nx = HALF;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else state <= state_nx;
   end

   // d0/z0 is the head; it keeps its value after the last pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         d0  <= '0;
         d1  <= '0;
         z0  <= 1'b0;
         z1  <= 1'b0;
      end else begin
         if (push && (mode == MODE_ACC || mode == MODE_LOAD))
            acc <= r;
         unique case (state)
            EMPTY: begin
               if (push) begin
                  d0 <= r;
                  z0 <= r_zero;
               end
            end
            HALF: begin
               if (push && pop) begin
                  d0 <= r;
                  z0 <= r_zero;
               end else if (push) begin
                  d1 <= r;
                  z1 <= r_zero;
               end
            end
            FULL: begin
               if (pop) begin
                  d0 <= d1;
                  z0 <= z1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_glogic_pipe.sv
// tb_glogic_pipe: randomized and directed checks of glogic_pipe
// against a queue-based reference model.
module tb_glogic_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [1:0]  mode;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        zero;

   logic        in_valid8;
   logic        in_ready8;
   logic [2:0]  op8;
   logic [1:0]  mode8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  y8;
   logic        zero8;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [16:0] mq[$];
   logic [15:0] macc = '0;

   always #5 clk = ~clk;

   glogic_pipe #(.WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .mode(mode), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero)
   );

   glogic_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op8), .mode(mode8), .a(a8), .b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .y(y8), .zero(zero8)
   );

   function automatic logic [15:0] ref_r(
      input logic [2:0]  o,
      input logic [1:0]  m,
      input logic [15:0] aa,
      input logic [15:0] bb,
      input logic [15:0] cur
   );
      logic [15:0] xx;
      logic [15:0] zz;
      if (m == 2'b10) return aa;
      xx = (m == 2'b01) ? cur : aa;
      zz = (m == 2'b01) ? aa : bb;
      case (o)
         3'd0: return xx & zz;
         3'd1: return xx | zz;
         3'd2: return xx ^ zz;
         3'd3: return ~(xx & zz);
         3'd4: return ~(xx | zz);
         3'd5: return ~(xx ^ zz);
         3'd6: return ~xx;
         default: return zz;
      endcase
   endfunction

   // advance one clock; the model decides accept/pop from its own occupancy
   task automatic tick();
      logic        pf;
      logic        af;
      logic [15:0] r;
      @(negedge clk);
      pf = out_ready && (mq.size() != 0);
      af = in_valid && (mq.size() < 2);
      r  = '0;
      if (af) begin
         r = ref_r(op, mode, a, b, macc);
         if (mode == 2'b01 || mode == 2'b10) macc = r;
      end
      if (pf) void'(mq.pop_front());
      if (af) mq.push_back({(r == 16'h0), r});
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      in_valid = 1'b1; out_ready = 1'b0;
      op = 3'd1; mode = 2'b00; a = 16'h5A5A; b = 16'h0101;
      tick();
      #3 rst_n = 1'b0;
      #1;
      mq.delete();
      macc = '0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_hs: got ov=%b ir=%b want ov=0 ir=1",
                  out_valid, in_ready);
      end
      n_cmp++;
      if (y !== 16'h0000 || zero !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_y: got y=%h z=%b want y=0000 z=0", y, zero);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b1; out_ready = 1'b1;
      op = 3'd0; mode = 2'b00; a = 16'hFFFF; b = 16'h0001;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || y !== 16'h0001) begin
         n_bad++;
         $display("FAIL reset_first: got ov=%b y=%h want ov=1 y=0001",
                  out_valid, y);
      end
      drain();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_drain: got ov=%b want 0", out_valid);
      end
   endtask

   task automatic test_direct();
      logic [15:0] ta[3] = '{16'hF0F0, 16'hA5A5, 16'h00FF};
      logic [15:0] tb[3] = '{16'h3C3C, 16'hA5A5, 16'h1234};
      logic [2:0]  to[3] = '{3'd0, 3'd2, 3'd6};
      logic [15:0] ty[3] = '{16'h3030, 16'h0000, 16'hFF00};
      logic        tz[3] = '{1'b0, 1'b1, 1'b0};
      in_valid = 1'b1; out_ready = 1'b1; mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         a = ta[i]; b = tb[i]; op = to[i];
         tick();
         n_cmp++;
         if (y !== ty[i] || zero !== tz[i]) begin
            n_bad++;
            $display("FAIL direct_fixed%0d: got y=%h z=%b want y=%h z=%b",
                     i, y, zero, ty[i], tz[i]);
         end
      end
      for (int i = 0; i < 12; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         op = 3'($urandom); mode = (i % 3 == 0) ? 2'b11 : 2'b00;
         tick();
         n_cmp++;
         if (mq.size() != 1 || y !== mq[0][15:0] || zero !== mq[0][16]) begin
            n_bad++;
            $display("FAIL direct_rand%0d: got y=%h z=%b want %h", i, y,
                     zero, (mq.size() != 0) ? mq[0] : 17'h0);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [15:0] want[3] = '{16'h0002, 16'h0004, 16'h0000};
      logic        wv[3] = '{1'b1, 1'b1, 1'b0};
      in_valid = 1'b1; out_ready = 1'b0;
      op = 3'd1; mode = 2'b00; b = 16'h0000;
      a = 16'h0001; tick();
      a = 16'h0002; tick();
      n_cmp++;
      if (in_ready !== 1'b0 || y !== 16'h0001) begin
         n_bad++;
         $display("FAIL bp_full: got ir=%b y=%h want ir=0 y=0001",
                  in_ready, y);
      end
      a = 16'h0004;
      tick();
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 16'h0001) begin
         n_bad++;
         $display("FAIL bp_held: got ir=%b ov=%b y=%h want 0 1 0001",
                  in_ready, out_valid, y);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) in_valid = 1'b0;
         tick();
         n_cmp++;
         if (out_valid !== wv[i] || (wv[i] && y !== want[i])) begin
            n_bad++;
            $display("FAIL bp_order%0d: got ov=%b y=%h want ov=%b y=%h",
                     i, out_valid, y, wv[i], want[i]);
         end
      end
      n_cmp++;
      if (mq.size() != 0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_count: got ir=%b model=%0d want ir=1 model=0",
                  in_ready, mq.size());
      end
   endtask

   task automatic test_accumulate();
      logic [15:0] ta[3] = '{16'hFFFF, 16'h0FF0, 16'h00FF};
      logic [1:0]  tm[3] = '{2'b10, 2'b01, 2'b01};
      logic [15:0] ty[3] = '{16'hFFFF, 16'h0FF0, 16'h00F0};
      in_valid = 1'b1; out_ready = 1'b1; op = 3'd0; b = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         a = ta[i]; mode = tm[i];
         tick();
         n_cmp++;
         if (y !== ty[i]) begin
            n_bad++;
            $display("FAIL acc_seq%0d: got %h want %h", i, y, ty[i]);
         end
      end
      n_cmp++;
      if (u_dut.acc !== 16'h00F0) begin
         n_bad++;
         $display("FAIL acc_final: got %h want 00f0", u_dut.acc);
      end
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         op = 3'($urandom); mode = 2'($urandom);
         tick();
         n_cmp++;
         if (mq.size() != 1 || y !== mq[0][15:0] || zero !== mq[0][16]) begin
            n_bad++;
            $display("FAIL acc_rand%0d: got y=%h z=%b want %h", i, y,
                     zero, (mq.size() != 0) ? mq[0] : 17'h0);
         end
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; out_ready = 1'b1; op = 3'd2; mode = 2'b00;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         tick();
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
             mq.size() != 1 || y !== mq[0][15:0]) begin
            n_bad++;
            $display("FAIL b2b%0d: got ir=%b ov=%b y=%h want 1 1 %h", i,
                     in_ready, out_valid, y,
                     (mq.size() != 0) ? mq[0][15:0] : 16'h0);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; out_ready = 1'b0;
      mode = 2'b10; a = 16'h1234; op = 3'd0; tick();
      mode = 2'b00; op = 3'd7; b = 16'h5555; tick();
      n_cmp++;
      if (in_ready !== 1'b0 || u_dut.acc !== 16'h1234) begin
         n_bad++;
         $display("FAIL rmid_pre: got ir=%b acc=%h want ir=0 acc=1234",
                  in_ready, u_dut.acc);
      end
      #3 rst_n = 1'b0;
      #1;
      mq.delete();
      macc = '0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_hs: got ov=%b ir=%b want ov=0 ir=1",
                  out_valid, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b1; out_ready = 1'b1;
      mode = 2'b01; op = 3'd1; a = 16'h0001;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || y !== 16'h0001) begin
         n_bad++;
         $display("FAIL rmid_acc: got ov=%b y=%h want ov=1 y=0001",
                  out_valid, y);
      end
      drain();
   endtask

   task automatic test_random();
      int bad_here = 0;
      for (int i = 0; i < 300; i++) begin
         if (!(in_valid && mq.size() == 2)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom);
            op = 3'($urandom); mode = 2'($urandom);
            if ($urandom_range(0, 7) == 0) a = b;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         n_cmp++;
         if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2) ||
             (mq.size() != 0 &&
              (y !== mq[0][15:0] || zero !== mq[0][16]))) begin
            n_bad++;
            if (bad_here < 5)
               $display("FAIL rand%0d: got ov=%b ir=%b y=%h z=%b model=%0d %h",
                        i, out_valid, in_ready, y, zero, mq.size(),
                        (mq.size() != 0) ? mq[0] : 17'h0);
            bad_here++;
         end
      end
      drain();
   endtask

   task automatic test_width8();
      logic [15:0] w;
      logic [7:0]  e;
      drain();
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      op8 = 3'd0; mode8 = 2'b00; a8 = 8'hF0; b8 = 8'h3C;
      tick();
      n_cmp++;
      if (out_valid8 !== 1'b1 || y8 !== 8'h30 || zero8 !== 1'b0) begin
         n_bad++;
         $display("FAIL w8_and: got ov=%b y=%h z=%b want 1 30 0",
                  out_valid8, y8, zero8);
      end
      for (int i = 0; i < 8; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
         w = ref_r(op8, 2'b00, {8'h00, a8}, {8'h00, b8}, 16'h0);
         e = w[7:0];
         tick();
         n_cmp++;
         if (y8 !== e || zero8 !== (e == 8'h00)) begin
            n_bad++;
            $display("FAIL w8_rand%0d: got y=%h z=%b want %h", i, y8,
                     zero8, e);
         end
      end
      in_valid8 = 1'b0;
      tick();
      n_cmp++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
         n_bad++;
         $display("FAIL w8_drain: got ov=%b ir=%b want 0 1",
                  out_valid8, in_ready8);
      end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0;
      op = '0; mode = '0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      op8 = '0; mode8 = '0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_direct();
      test_backpressure();
      test_accumulate();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
